// File: rtl/bus_pkg.sv
// Shared register map and bit positions for the bus-attached stream FIFO.
package bus_pkg;

  localparam logic [2:0] OFS_ID      = 3'd0;
  localparam logic [2:0] OFS_STATUS  = 3'd1;
  localparam logic [2:0] OFS_COUNT   = 3'd2;
  localparam logic [2:0] OFS_DATA    = 3'd3;
  localparam logic [2:0] OFS_CONTROL = 3'd4;
  localparam logic [2:0] OFS_PUSHCNT = 3'd5;
  localparam logic [2:0] OFS_POPCNT  = 3'd6;

  localparam logic [15:0] FIFO_ID = 16'hF1F0;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_EN    = 3;

  localparam int CTL_EN        = 0;
  localparam int CTL_CLR       = 1;
  localparam int CTL_CLR_STATS = 2;

  function automatic logic [15:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic en);
    logic [15:0] w;
    w = '0;
    w[ST_EMPTY] = empty;
    w[ST_FULL]  = full;
    w[ST_OVF]   = ovf;
    w[ST_EN]    = en;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO core: memory, wrapping pointers and occupancy count.
// The caller only asserts push when there is room (or a pop in the same cycle) and pop when non-empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  // Storage is not reset, so it stays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head word is read straight from the array so a new head follows each pop with no bubble.
  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));

endmodule

// File: rtl/bus_stream_fifo.sv
// Bus slave that accepts 16-bit words from software and streams them out over valid/ready.
// Optional push/pop statistics counters are built when BUS_STREAM_FIFO_STATS_EN is defined.
module bus_stream_fifo
  import bus_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'h0100,
  parameter int          DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baddr,
  input  logic [15:0] bwrdata,
  output logic [15:0] brddata,
  input  logic        bwr,
  input  logic        bstrobe,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        fifo_empty,
  output logic        fifo_full
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   ofs;
  logic          hit;
  logic [2:0]    sel;
  logic          wr_strobe;
  logic          data_wr;
  logic          ctl_wr;
  logic          clear;
  logic          pop;
  logic          push_ok;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          enable_reg;
  logic          overflow_reg;
  logic [15:0]   brddata_reg;
  logic [15:0]   rd_next;
  logic [15:0]   pushcnt;
  logic [15:0]   popcnt;

  // Offset arithmetic wraps for addresses below BASE, so a single compare covers the window.
  assign ofs       = baddr - BASE;
  assign hit       = (ofs < 16'd8);
  assign sel       = ofs[2:0];
  assign wr_strobe = bstrobe & bwr & hit;
  assign data_wr   = wr_strobe & (sel == OFS_DATA);
  assign ctl_wr    = wr_strobe & (sel == OFS_CONTROL);
  assign clear     = ctl_wr & bwrdata[CTL_CLR];

  assign dout_valid = enable_reg & ~empty;
  assign pop        = dout_valid & dout_ready & ~clear;
  assign push_ok    = data_wr & (~full | pop);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .clear (clear),
    .wdata (bwrdata),
    .rdata (dout),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (ctl_wr) enable_reg <= bwrdata[CTL_EN];
      if (clear) begin
        overflow_reg <= 1'b0;
      end else if (data_wr && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

`ifdef BUS_STREAM_FIFO_STATS_EN
  logic [15:0] pushcnt_reg;
  logic [15:0] popcnt_reg;
  logic        clr_stats;

  assign clr_stats = ctl_wr & bwrdata[CTL_CLR_STATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pushcnt_reg <= '0;
      popcnt_reg  <= '0;
    end else if (clr_stats) begin
      pushcnt_reg <= '0;
      popcnt_reg  <= '0;
    end else begin
      if (push_ok) pushcnt_reg <= pushcnt_reg + 16'd1;
      if (pop)     popcnt_reg  <= popcnt_reg + 16'd1;
    end
  end

  assign pushcnt = pushcnt_reg;
  assign popcnt  = popcnt_reg;
`else
  assign pushcnt = 16'd0;
  assign popcnt  = 16'd0;
`endif

  always_comb begin
    rd_next = 16'd0;
    if (hit) begin
      case (sel)
        OFS_ID:      rd_next = FIFO_ID;
        OFS_STATUS:  rd_next = status_word(empty, full, overflow_reg, enable_reg);
        OFS_COUNT:   rd_next = 16'(count);
        OFS_CONTROL: rd_next = {15'd0, enable_reg};
        OFS_PUSHCNT: rd_next = pushcnt;
        OFS_POPCNT:  rd_next = popcnt;
        default:     rd_next = 16'd0;
      endcase
    end
  end

  // Read data is registered every cycle from the address alone; reads have no side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brddata_reg <= 16'd0;
    end else begin
      brddata_reg <= rd_next;
    end
  end

  assign brddata    = brddata_reg;
  assign fifo_empty = empty;
  assign fifo_full  = full;

endmodule

// File: tb/tb_bus_stream_fifo.sv
// Directed bench for bus_stream_fifo with a queue-based reference model checked every cycle.
// Expected statistics follow BUS_STREAM_FIFO_STATS_EN when it is defined for the build.
module tb_bus_stream_fifo;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          DEPTH = 16;
`ifdef BUS_STREAM_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baddr = 16'h0000;
  logic [15:0] bwrdata = 16'h0000;
  logic [15:0] brddata;
  logic        bwr = 1'b0;
  logic        bstrobe = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        fifo_empty;
  logic        fifo_full;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_q[$];
  logic        m_en;
  logic        m_ovf;
  logic [15:0] m_pc;
  logic [15:0] m_pp;
  logic [15:0] got[$];

  bus_stream_fifo #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .baddr      (baddr),
    .bwrdata    (bwrdata),
    .brddata    (brddata),
    .bwr        (bwr),
    .bstrobe    (bstrobe),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_reg(input logic [15:0] addr);
    logic [15:0] o;
    int sz;
    o  = addr - BASE;
    sz = m_q.size();
    case (o)
      16'd0:   return 16'hF1F0;
      16'd1:   return {12'd0, m_en, m_ovf, sz == DEPTH, sz == 0};
      16'd2:   return 16'(sz);
      16'd4:   return {15'd0, m_en};
      16'd5:   return STATS ? m_pc : 16'd0;
      16'd6:   return STATS ? m_pp : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  // Model: evaluate each clock edge from the inputs and the queue contents.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_en  = 1'b0;
      m_ovf = 1'b0;
      m_pc  = 16'd0;
      m_pp  = 16'd0;
    end else begin
      int sz;
      bit do_pop;
      logic [15:0] o;
      if (dout_valid && dout_ready) got.push_back(dout);
      sz = m_q.size();
      o  = baddr - BASE;
      do_pop = m_en && (sz > 0) && dout_ready;
      if (bstrobe && bwr && o == 16'd4 && bwrdata[1]) begin
        m_q.delete();
        m_ovf  = 1'b0;
        do_pop = 1'b0;
      end
      if (do_pop) begin
        void'(m_q.pop_front());
        m_pp = m_pp + 16'd1;
      end
      if (bstrobe && bwr && o == 16'd3) begin
        if (sz < DEPTH || do_pop) begin
          m_q.push_back(bwrdata);
          m_pc = m_pc + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (bstrobe && bwr && o == 16'd4) begin
        m_en = bwrdata[0];
        if (bwrdata[2]) begin
          m_pc = 16'd0;
          m_pp = 16'd0;
        end
      end
    end
  end

  // Per-cycle compare of stream and LED outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_valid;
      exp_valid = m_en && (m_q.size() > 0);
      check("dout_valid", {15'd0, dout_valid}, {15'd0, exp_valid});
      check("fifo_empty", {15'd0, fifo_empty}, {15'd0, m_q.size() == 0});
      check("fifo_full", {15'd0, fifo_full}, {15'd0, m_q.size() == DEPTH});
      if (exp_valid) check("dout", dout, m_q[0]);
    end
  end

  // Bus tasks are entered and left on a falling edge.
  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    baddr   = addr;
    bwrdata = data;
    bwr     = 1'b1;
    bstrobe = 1'b1;
    @(negedge clk);
    bstrobe = 1'b0;
    bwr     = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    logic [15:0] exp;
    baddr   = addr;
    bwr     = 1'b0;
    bstrobe = 1'b1;
    @(negedge clk);
    bstrobe = 1'b0;
    exp = model_reg(addr);
    @(negedge clk);
    data = brddata;
    check("brddata", data, exp);
    $display("read  addr=%h data=%h", addr, data);
  endtask

  logic [15:0] d;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", {15'd0, dout_valid}, 16'd0);
    check("rst_brddata", brddata, 16'd0);

    // reset state
    bus_read(BASE + 16'd0, d); check("id", d, 16'hF1F0);
    bus_read(BASE + 16'd1, d); check("status_rst", d, 16'h0001);

    // two words, then back-to-back drain
    bus_write(BASE + 16'd4, 16'h0001);
    bus_write(BASE + 16'd3, 16'h1234);
    bus_write(BASE + 16'd3, 16'hABCD);
    bus_read(BASE + 16'd2, d); check("count2", d, 16'd2);
    check("head1234", dout, 16'h1234);
    dout_ready = 1'b1;
    @(negedge clk); check("headABCD", dout, 16'hABCD);
    @(negedge clk); check("empty_after", {15'd0, fifo_empty}, 16'd1);
    dout_ready = 1'b0;
    $display("xfer  two-word drain done");

    // unused locations and unmapped addresses
    bus_read(BASE + 16'd3, d);
    bus_read(BASE + 16'd7, d);
    bus_read(BASE + 16'd8, d);
    bus_read(16'h00FF, d);
    bus_write(16'h0203, 16'h5555);
    bus_read(BASE + 16'd2, d); check("unmapped_wr", d, 16'd0);

    // overflow with enable off, then ordered drain
    bus_write(BASE + 16'd4, 16'h0002);
    for (int i = 1; i <= 17; i++) bus_write(BASE + 16'd3, 16'h0100 + 16'(i));
    bus_read(BASE + 16'd2, d); check("count16", d, 16'd16);
    bus_read(BASE + 16'd1, d); check("status_full_ovf", d, 16'h0006);
    got.delete();
    dout_ready = 1'b1;
    bus_write(BASE + 16'd4, 16'h0001);
    repeat (20) @(negedge clk);
    dout_ready = 1'b0;
    check("drain_n", 16'(got.size()), 16'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) check("drain_word", got[i], 16'h0101 + 16'(i));
    $display("xfer  drained %0d words", got.size());

    // push into a full FIFO while a pop happens in the same cycle
    bus_write(BASE + 16'd4, 16'h0002);
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) bus_write(BASE + 16'd3, 16'h0200 + 16'(i));
    bus_write(BASE + 16'd4, 16'h0001);
    bus_write(BASE + 16'd3, 16'hBEEF);
    dout_ready = 1'b0;
    bus_read(BASE + 16'd2, d); check("count_full_pop", d, 16'd16);
    bus_read(BASE + 16'd1, d); check("status_no_ovf", d, 16'h000A);

    // overflow, drain to five words, then clear with enable kept
    bus_write(BASE + 16'd3, 16'hDEAD);
    dout_ready = 1'b1;
    repeat (11) @(negedge clk);
    dout_ready = 1'b0;
    bus_read(BASE + 16'd2, d); check("count5", d, 16'd5);
    bus_read(BASE + 16'd1, d); check("status5", d, 16'h0006 & 16'h0004 | 16'h0008);
    bus_write(BASE + 16'd4, 16'h0003);
    bus_read(BASE + 16'd2, d); check("count_clr", d, 16'd0);
    bus_read(BASE + 16'd1, d); check("status_clr", d, 16'h0009);

    // statistics
    bus_write(BASE + 16'd4, 16'h0004);
    for (int i = 0; i < 3; i++) bus_write(BASE + 16'd3, 16'h0300 + 16'(i));
    bus_write(BASE + 16'd4, 16'h0001);
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    dout_ready = 1'b0;
    bus_read(BASE + 16'd5, d); check("pushcnt", d, STATS ? 16'd3 : 16'd0);
    bus_read(BASE + 16'd6, d); check("popcnt", d, STATS ? 16'd2 : 16'd0);
    bus_write(BASE + 16'd4, 16'h0004);
    bus_read(BASE + 16'd5, d); check("pushcnt_clr", d, 16'd0);
    bus_read(BASE + 16'd6, d); check("popcnt_clr", d, 16'd0);

    // asynchronous reset while data is pending
    bus_write(BASE + 16'd4, 16'h0001);
    bus_write(BASE + 16'd3, 16'h4444);
    check("valid_pre_rst", {15'd0, dout_valid}, 16'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("valid_async_rst", {15'd0, dout_valid}, 16'd0);
    check("empty_async_rst", {15'd0, fifo_empty}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    bus_read(BASE + 16'd2, d); check("count_after_rst", d, 16'd0);
    bus_read(BASE + 16'd1, d); check("status_after_rst", d, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
